// File: rtl/clock_pkg.sv
// clock_pkg: key channel FSM state encoding and counter sizing shared by the key conditioner
package clock_pkg;
  typedef enum logic [2:0] {
    KS_IDLE   = 3'd0,
    KS_PDEB   = 3'd1,
    KS_HELD   = 3'd2,
    KS_REPEAT = 3'd3,
    KS_RDEB   = 3'd4
  } ks_e;
  function automatic int cnt_w(input int deb, input int hold, input int rep);
    int m;
    m = (deb > hold) ? deb : hold;
    m = (m > rep) ? m : rep;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/key_chan.sv
// key_chan: one key channel, two-flop synchronizer plus debounce/auto-repeat FSM
// Ports: clk, rst_n (async active-low), key (raw async level), rep_en (repeat enable),
//        pulse (registered one-cycle increment strobe), level (registered debounced state)
module key_chan
  import clock_pkg::*;
#(
  parameter int DEB_CYC  = 1_000_000,
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  input  logic rep_en,
  output logic pulse,
  output logic level
);
  localparam int CW = cnt_w(DEB_CYC, HOLD_CYC, REP_CYC);
  localparam logic [CW-1:0] DEB_C   = CW'(DEB_CYC);
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_M1  = CW'(REP_CYC - 1);
  logic [1:0]    sync_q, sync_d;
  ks_e           state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          level_q, level_d;
  logic          s;
  assign s = sync_q[1];
  always_comb begin
    sync_d  = {sync_q[0], key};
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      KS_IDLE: begin
        cnt_d = '0;
        if (s) begin
          state_d = KS_PDEB;
          cnt_d   = CW'(1);
        end
      end
      KS_PDEB: begin
        if (!s) begin
          state_d = KS_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_C) begin
          state_d = KS_HELD;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      KS_HELD: begin
        if (!s) begin
          state_d = KS_RDEB;
          cnt_d   = CW'(1);
        end else if (rep_en && cnt_q == HOLD_M1) begin
          state_d = KS_REPEAT;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
      KS_REPEAT: begin
        if (!s) begin
          state_d = KS_RDEB;
          cnt_d   = CW'(1);
        end else if (!rep_en) begin
          // saturated count can never match HOLD_CYC-1, so repeat stays off until re-press
          state_d = KS_HELD;
          cnt_d   = '1;
        end else if (cnt_q == REP_M1) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      KS_RDEB: begin
        if (s) begin
          // a release bounce restarts the hold timer
          state_d = KS_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_C) begin
          state_d = KS_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = KS_IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = state_d inside {KS_HELD, KS_REPEAT, KS_RDEB};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= KS_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end
  assign pulse = pulse_q;
  assign level = level_q;
endmodule

// File: rtl/key_pulse_conditioner.sv
// key_pulse_conditioner: NKEY independent debounced, auto-repeating key pulse channels
// Ports: Clk, RST (async active-low), Keys (raw async levels), RepEn (per-key repeat enable),
//        Pulse (one-cycle increment strobes), Level (debounced key states)
module key_pulse_conditioner #(
  parameter int NKEY     = 4,
  parameter int DEB_CYC  = 1_000_000,
  parameter int HOLD_CYC = 50_000_000,
  parameter int REP_CYC  = 10_000_000
) (
  input  logic            Clk,
  input  logic            RST,
  input  logic [NKEY-1:0] Keys,
  input  logic [NKEY-1:0] RepEn,
  output logic [NKEY-1:0] Pulse,
  output logic [NKEY-1:0] Level
);
  for (genvar i = 0; i < NKEY; i++) begin : g_chan
    key_chan #(
      .DEB_CYC (DEB_CYC),
      .HOLD_CYC(HOLD_CYC),
      .REP_CYC (REP_CYC)
    ) u_chan (
      .clk   (Clk),
      .rst_n (RST),
      .key   (Keys[i]),
      .rep_en(RepEn[i]),
      .pulse (Pulse[i]),
      .level (Level[i])
    );
  end
endmodule

// File: tb/tb_key_pulse_conditioner.sv
// tb_key_pulse_conditioner: scoreboard bench for key_pulse_conditioner with DEB=4, HOLD=20, REP=5
module tb_key_pulse_conditioner;
  logic       Clk = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] Keys = 4'b0;
  logic [3:0] RepEn = 4'b0;
  logic [3:0] Pulse;
  logic [3:0] Level;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [3:0] exp_m;
  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;
  exp_t exp_q[$];
  key_pulse_conditioner #(
    .NKEY    (4),
    .DEB_CYC (4),
    .HOLD_CYC(20),
    .REP_CYC (5)
  ) dut (
    .Clk  (Clk),
    .RST  (RST),
    .Keys (Keys),
    .RepEn(RepEn),
    .Pulse(Pulse),
    .Level(Level)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    if (mon_en) begin
      exp_m = 4'b0;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        exp_m = exp_q[0].mask;
        void'(exp_q.pop_front());
      end
      if (Pulse !== 4'b0 || exp_m != 4'b0) begin
        n_tests++;
        if (Pulse !== exp_m) begin
          n_fail++;
          $display("FAIL pulse cyc=%0d got=%b exp=%b", cyc, Pulse, exp_m);
        end
      end
    end
  end
  task automatic test_drained(input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing pulses: %0d left, next at cyc %0d", name, exp_q.size(), exp_q[0].cyc);
      exp_q.delete();
    end
  endtask
  task automatic test_reset();
    #2 RST = 1'b0;
    repeat (3) @(negedge Clk);
    n_tests += 2;
    if (Pulse !== 4'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0000", Pulse); end
    if (Level !== 4'b0) begin n_fail++; $display("FAIL reset_level got=%b exp=0000", Level); end
    RST = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge Clk);
    n_tests += 2;
    if (Pulse !== 4'b0) begin n_fail++; $display("FAIL post_reset_pulse got=%b exp=0000", Pulse); end
    if (Level !== 4'b0) begin n_fail++; $display("FAIL post_reset_level got=%b exp=0000", Level); end
  endtask
  task automatic test_clean_press();
    int c;
    c = cyc;
    Keys[0] = 1'b1;
    exp_q.push_back('{c + 7, 4'b0001});
    for (int i = 0; i < 25; i++) begin
      if (i == 12) Keys[0] = 1'b0;
      n_tests++;
      if (Level[0] !== (i >= 7 && i <= 18)) begin
        n_fail++;
        $display("FAIL clean_level i=%0d got=%b exp=%b", i, Level[0], (i >= 7 && i <= 18));
      end
      @(negedge Clk);
    end
    test_drained("clean_press");
  endtask
  task automatic test_bounce();
    bit vals[7];
    int lens[7];
    vals = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    lens = '{2, 1, 3, 2, 1, 2, 3};
    for (int s = 0; s < 7; s++) begin
      Keys[1] = vals[s];
      for (int j = 0; j < lens[s]; j++) begin
        n_tests++;
        if (Level[1] !== 1'b0) begin n_fail++; $display("FAIL bounce_level seg=%0d got=%b exp=0", s, Level[1]); end
        @(negedge Clk);
      end
    end
    Keys[1] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      n_tests++;
      if (Level[1] !== 1'b0) begin n_fail++; $display("FAIL bounce_level tail=%0d got=%b exp=0", j, Level[1]); end
      @(negedge Clk);
    end
    test_drained("bounce");
  endtask
  task automatic test_auto_repeat();
    int c;
    c = cyc;
    Keys[2] = 1'b1;
    RepEn[2] = 1'b1;
    exp_q.push_back('{c + 7, 4'b0100});
    for (int j = 0; j < 8; j++) exp_q.push_back('{c + 27 + 5 * j, 4'b0100});
    for (int i = 0; i < 75; i++) begin
      if (i == 60) Keys[2] = 1'b0;
      n_tests++;
      if (Level[2] !== (i >= 7 && i <= 66)) begin
        n_fail++;
        $display("FAIL repeat_level i=%0d got=%b exp=%b", i, Level[2], (i >= 7 && i <= 66));
      end
      @(negedge Clk);
    end
    RepEn[2] = 1'b0;
    test_drained("auto_repeat");
  endtask
  task automatic test_release_bounce();
    int c;
    c = cyc;
    Keys[0] = 1'b1;
    RepEn[0] = 1'b1;
    exp_q.push_back('{c + 7, 4'b0001});
    exp_q.push_back('{c + 35, 4'b0001});
    exp_q.push_back('{c + 40, 4'b0001});
    for (int i = 0; i < 50; i++) begin
      if (i == 10) Keys[0] = 1'b0;
      if (i == 12) Keys[0] = 1'b1;
      if (i == 38) Keys[0] = 1'b0;
      n_tests++;
      if (Level[0] !== (i >= 7 && i <= 44)) begin
        n_fail++;
        $display("FAIL rel_bounce_level i=%0d got=%b exp=%b", i, Level[0], (i >= 7 && i <= 44));
      end
      @(negedge Clk);
    end
    RepEn[0] = 1'b0;
    test_drained("release_bounce");
  endtask
  task automatic test_reset_mid();
    int c;
    int d;
    c = cyc;
    Keys[2] = 1'b1;
    RepEn[2] = 1'b1;
    exp_q.push_back('{c + 7, 4'b0100});
    exp_q.push_back('{c + 27, 4'b0100});
    exp_q.push_back('{c + 32, 4'b0100});
    repeat (32) @(negedge Clk);
    #1 RST = 1'b0;
    #1;
    n_tests += 2;
    if (Pulse !== 4'b0) begin n_fail++; $display("FAIL mid_reset_pulse got=%b exp=0000", Pulse); end
    if (Level !== 4'b0) begin n_fail++; $display("FAIL mid_reset_level got=%b exp=0000", Level); end
    RepEn[2] = 1'b0;
    repeat (3) @(negedge Clk);
    n_tests++;
    if (Level !== 4'b0) begin n_fail++; $display("FAIL held_reset_level got=%b exp=0000", Level); end
    test_drained("pre_reset");
    RST = 1'b1;
    d = cyc;
    exp_q.push_back('{d + 7, 4'b0100});
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (Level[2] !== (i >= 7)) begin
        n_fail++;
        $display("FAIL after_reset_level i=%0d got=%b exp=%b", i, Level[2], (i >= 7));
      end
      @(negedge Clk);
    end
    Keys[2] = 1'b0;
    repeat (12) @(negedge Clk);
    n_tests++;
    if (Level[2] !== 1'b0) begin n_fail++; $display("FAIL after_reset_release got=%b exp=0", Level[2]); end
    test_drained("reset_mid");
  endtask
  task automatic test_simultaneous();
    int c;
    c = cyc;
    Keys = 4'b1111;
    exp_q.push_back('{c + 7, 4'b1111});
    for (int i = 0; i < 25; i++) begin
      if (i == 8) Keys = 4'b0000;
      n_tests++;
      if (Level !== ((i >= 7 && i <= 14) ? 4'b1111 : 4'b0000)) begin
        n_fail++;
        $display("FAIL simul_level i=%0d got=%b exp=%b", i, Level, ((i >= 7 && i <= 14) ? 4'b1111 : 4'b0000));
      end
      @(negedge Clk);
    end
    test_drained("simultaneous");
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_bounce();
    test_reset_mid();
    test_simultaneous();
    repeat (5) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
